lsu: RTL and testbench

- Load/store unit for the ECAP5-DPROC execute/memory stage. It replaces the stubbed memory path with a real Wishbone B4 master.
- Accepts one RV32I load or store per transaction over a valid/ready handshake and performs byte-lane steering, sign/zero extension and misalignment detection.
- Supports pipelined or classic Wishbone and has an ack timeout.
- Presents the result to writeback with a valid/ready handshake.

---
 rtl/lsu.sv | 194 +++++++++++++++++++
 tb/tb_lsu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: one RV32I load or store per request, issued as a single
// Wishbone B4 (pipelined or classic) transfer with lane steering and ack timeout.
module lsu #(
  parameter int PIPELINED   = 1,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        input_ready_o,
  input  logic        input_valid_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i,
  output logic        wb_cyc_o,
  input  logic        output_ready_i,
  output logic        output_valid_o,
  output logic        result_write_o,
  output logic [4:0]  result_addr_o,
  output logic [31:0] result_o,
  output logic        misaligned_o,
  output logic        bus_error_o
);

  localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]       r_state;
  logic             r_store;
  logic [1:0]       r_size;
  logic             r_uns;
  logic [1:0]       r_off;
  logic [4:0]       r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_adr;
  logic [31:0]      r_dat;
  logic [3:0]       r_sel;
  logic             r_we;
  logic             r_stb;
  logic             r_cyc;
  logic             r_valid;
  logic             r_write;
  logic [31:0]      r_result;
  logic             r_mis;
  logic             r_berr;

  logic [1:0]       w_size;
  logic             w_mis;
  logic             w_expire;

  function automatic logic [3:0] f_sel(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   f_sel = 4'b0001 << off;
      2'b01:   f_sel = 4'b0011 << off;
      default: f_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_store_dat(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   f_store_dat = {4{wd[7:0]}};
      2'b01:   f_store_dat = {2{wd[15:0]}};
      default: f_store_dat = wd;
    endcase
  endfunction

  function automatic logic [31:0] f_load_ext(input logic [31:0] dat, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = dat >> {off, 3'b000};
    case (size)
      2'b00:   f_load_ext = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   f_load_ext = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: f_load_ext = dat;
    endcase
  endfunction

  assign w_size   = funct3_i[1:0];
  // size 2'b11 is handled as a word, so size[1] covers both word encodings
  assign w_mis    = ((w_size == 2'b01) && addr_i[0]) || (w_size[1] && (addr_i[1:0] != 2'b00));
  assign w_expire = (ACK_TIMEOUT != 0) && (32'(r_cnt) == ACK_TIMEOUT - 1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_store  <= 1'b0;
      r_size   <= 2'b00;
      r_uns    <= 1'b0;
      r_off    <= 2'b00;
      r_rd     <= 5'd0;
      r_cnt    <= '0;
      r_adr    <= 32'h0;
      r_dat    <= 32'h0;
      r_sel    <= 4'h0;
      r_we     <= 1'b0;
      r_stb    <= 1'b0;
      r_cyc    <= 1'b0;
      r_valid  <= 1'b0;
      r_write  <= 1'b0;
      r_result <= 32'h0;
      r_mis    <= 1'b0;
      r_berr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (input_valid_i) begin
            r_store <= store_i;
            r_size  <= w_size;
            r_uns   <= funct3_i[2];
            r_off   <= addr_i[1:0];
            r_rd    <= rd_i;
            r_cnt   <= '0;
            if (w_mis) begin
              r_state  <= S_RESP;
              r_valid  <= 1'b1;
              r_mis    <= 1'b1;
              r_write  <= 1'b0;
              r_result <= 32'h0;
            end else begin
              r_state <= S_REQ;
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_we    <= store_i;
              r_adr   <= {addr_i[31:2], 2'b00};
              r_sel   <= f_sel(w_size, addr_i[1:0]);
              r_dat   <= f_store_dat(w_size, wdata_i);
            end
          end
        end
        S_REQ, S_WAIT: begin
          // ack takes priority over a timeout expiring in the same cycle
          if (wb_ack_i) begin
            r_state  <= S_RESP;
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_valid  <= 1'b1;
            r_result <= r_store ? 32'h0 : f_load_ext(wb_dat_i, r_off, r_size, r_uns);
            r_write  <= !r_store && (r_rd != 5'd0);
          end else if (w_expire) begin
            r_state  <= S_RESP;
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_valid  <= 1'b1;
            r_berr   <= 1'b1;
            r_result <= 32'h0;
            r_write  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if ((r_state == S_REQ) && (PIPELINED != 0) && !wb_stall_i) begin
              r_stb   <= 1'b0;
              r_state <= S_WAIT;
            end
          end
        end
        default: begin
          if (output_ready_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
            r_berr  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign input_ready_o  = (r_state == S_IDLE);
  assign wb_adr_o       = r_adr;
  assign wb_dat_o       = r_dat;
  assign wb_we_o        = r_we;
  assign wb_sel_o       = r_sel;
  assign wb_stb_o       = r_stb;
  assign wb_cyc_o       = r_cyc;
  assign output_valid_o = r_valid;
  assign result_write_o = r_write;
  assign result_addr_o  = r_rd;
  assign result_o       = r_result;
  assign misaligned_o   = r_mis;
  assign bus_error_o    = r_berr;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: instance a is pipelined with the default timeout,
// instance b is classic with a short timeout.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        store;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, dat_i;
  logic [4:0]  rd;
  logic        out_rdy;

  logic        va, acka, stalla;
  logic        a_iready, a_we, a_stb, a_cyc, a_valid, a_write, a_mis, a_berr;
  logic [31:0] a_adr, a_dat, a_result;
  logic [3:0]  a_sel;
  logic [4:0]  a_raddr;

  logic        vb, ackb, stallb;
  logic        b_iready, b_we, b_stb, b_cyc, b_valid, b_write, b_mis, b_berr;
  logic [31:0] b_adr, b_dat, b_result;
  logic [3:0]  b_sel;
  logic [4:0]  b_raddr;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu #(.PIPELINED(1), .ACK_TIMEOUT(255)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .input_ready_o(a_iready), .input_valid_i(va),
    .store_i(store), .funct3_i(f3), .addr_i(addr), .wdata_i(wdata), .rd_i(rd),
    .wb_adr_o(a_adr), .wb_dat_i(dat_i), .wb_dat_o(a_dat), .wb_we_o(a_we),
    .wb_sel_o(a_sel), .wb_stb_o(a_stb), .wb_ack_i(acka), .wb_stall_i(stalla),
    .wb_cyc_o(a_cyc), .output_ready_i(out_rdy), .output_valid_o(a_valid),
    .result_write_o(a_write), .result_addr_o(a_raddr), .result_o(a_result),
    .misaligned_o(a_mis), .bus_error_o(a_berr)
  );

  lsu #(.PIPELINED(0), .ACK_TIMEOUT(4)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .input_ready_o(b_iready), .input_valid_i(vb),
    .store_i(store), .funct3_i(f3), .addr_i(addr), .wdata_i(wdata), .rd_i(rd),
    .wb_adr_o(b_adr), .wb_dat_i(dat_i), .wb_dat_o(b_dat), .wb_we_o(b_we),
    .wb_sel_o(b_sel), .wb_stb_o(b_stb), .wb_ack_i(ackb), .wb_stall_i(stallb),
    .wb_cyc_o(b_cyc), .output_ready_i(out_rdy), .output_valid_o(b_valid),
    .result_write_o(b_write), .result_addr_o(b_raddr), .result_o(b_result),
    .misaligned_o(b_mis), .bus_error_o(b_berr)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit sel_b, input logic st, input logic [2:0] fn,
                       input logic [31:0] ad, input logic [31:0] wd, input logic [4:0] r);
    check_eq("in_ready", sel_b ? b_iready : a_iready, 1);
    store = st; f3 = fn; addr = ad; wdata = wd; rd = r;
    if (sel_b) vb = 1'b1; else va = 1'b1;
    tick();
    va = 1'b0; vb = 1'b0;
  endtask

  task automatic handshake_a();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    check_eq("a_done_valid", a_valid, 0);
    check_eq("a_done_ready", a_iready, 1);
  endtask

  task automatic handshake_b();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    check_eq("b_done_valid", b_valid, 0);
    check_eq("b_done_ready", b_iready, 1);
  endtask

  // Pipelined transfer on instance a: ack in the cycle after stb
  task automatic xact_a(input string tag, input logic st, input logic [2:0] fn,
                        input logic [31:0] ad, input logic [31:0] wd, input logic [4:0] r,
                        input logic [31:0] rdat, input logic [31:0] eadr, input logic [3:0] esel,
                        input logic [31:0] edat, input logic [31:0] eres, input logic ewr);
    issue(0, st, fn, ad, wd, r);
    check_eq({tag, "_cyc_t1"}, a_cyc, 1);
    check_eq({tag, "_stb_t1"}, a_stb, 1);
    check_eq({tag, "_adr"}, a_adr, eadr);
    check_eq({tag, "_sel"}, a_sel, esel);
    check_eq({tag, "_we"}, a_we, st);
    if (st) check_eq({tag, "_dat_o"}, a_dat, edat);
    tick();
    check_eq({tag, "_stb_t2"}, a_stb, 0);
    check_eq({tag, "_cyc_t2"}, a_cyc, 1);
    check_eq({tag, "_valid_t2"}, a_valid, 0);
    dat_i = rdat; acka = 1'b1;
    tick();
    acka = 1'b0;
    check_eq({tag, "_valid_t3"}, a_valid, 1);
    check_eq({tag, "_cyc_t3"}, a_cyc, 0);
    check_eq({tag, "_write"}, a_write, ewr);
    check_eq({tag, "_raddr"}, a_raddr, r);
    check_eq({tag, "_mis"}, a_mis, 0);
    check_eq({tag, "_berr"}, a_berr, 0);
    if (!st) check_eq({tag, "_result"}, a_result, eres);
    handshake_a();
  endtask

  initial begin
    rst_n = 1'b0; store = 1'b0; f3 = 3'b000; addr = 32'h0; wdata = 32'h0; rd = 5'd0;
    dat_i = 32'h0; out_rdy = 1'b0;
    va = 1'b0; acka = 1'b0; stalla = 1'b0;
    vb = 1'b0; ackb = 1'b0; stallb = 1'b0;
    tick(); tick();
    check_eq("rst_cyc", a_cyc, 0);
    check_eq("rst_stb", a_stb, 0);
    check_eq("rst_valid", a_valid, 0);
    check_eq("rst_result", a_result, 0);
    check_eq("rst_sel", a_sel, 0);
    check_eq("rst_b_cyc", b_cyc, 0);
    rst_n = 1'b1;
    tick();
    check_eq("rst_ready", a_iready, 1);

    xact_a("lb",  0, 3'b000, 32'h0000_1003, 32'h0, 5'd1, 32'h80AA_BBCC, 32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80, 1);
    xact_a("lhu", 0, 3'b101, 32'h0000_2002, 32'h0, 5'd2, 32'hBEEF_1234, 32'h0000_2000, 4'b1100, 32'h0, 32'h0000_BEEF, 1);
    xact_a("lh",  0, 3'b001, 32'h0000_2002, 32'h0, 5'd2, 32'hBEEF_1234, 32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_BEEF, 1);
    xact_a("sb",  1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 5'd0, 32'h0, 32'h0000_3000, 4'b0010, 32'hA5A5_A5A5, 32'h0, 0);
    xact_a("sh",  1, 3'b001, 32'h0000_3002, 32'h1234_CAFE, 5'd6, 32'h0, 32'h0000_3000, 4'b1100, 32'hCAFE_CAFE, 32'h0, 0);
    xact_a("sw",  1, 3'b010, 32'h0000_3004, 32'h0102_0304, 5'd6, 32'h0, 32'h0000_3004, 4'b1111, 32'h0102_0304, 32'h0, 0);
    xact_a("lw0", 0, 3'b010, 32'h0000_4000, 32'h0, 5'd0, 32'h1234_5678, 32'h0000_4000, 4'b1111, 32'h0, 32'h1234_5678, 0);
    xact_a("lbu", 0, 3'b100, 32'h0000_4001, 32'h0, 5'd8, 32'h0000_9A00, 32'h0000_4000, 4'b0010, 32'h0, 32'h0000_009A, 1);

    // Misaligned word: no bus activity, response held while writeback stalls
    issue(0, 0, 3'b010, 32'h0000_4002, 32'h0, 5'd5);
    check_eq("mis_valid", a_valid, 1);
    check_eq("mis_flag", a_mis, 1);
    check_eq("mis_cyc", a_cyc, 0);
    check_eq("mis_write", a_write, 0);
    check_eq("mis_raddr", a_raddr, 5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("mis_hold_valid", a_valid, 1);
      check_eq("mis_hold_flag", a_mis, 1);
      check_eq("mis_hold_cyc", a_cyc, 0);
      check_eq("mis_hold_ready", a_iready, 0);
    end
    handshake_a();
    check_eq("mis_clear", a_mis, 0);
    issue(0, 0, 3'b001, 32'h0000_1001, 32'h0, 5'd5);
    check_eq("mis_h_flag", a_mis, 1);
    check_eq("mis_h_cyc", a_cyc, 0);
    handshake_a();

    // Pipelined stall: stall for three cycles keeps stb up for four
    stalla = 1'b1;
    issue(0, 0, 3'b010, 32'h0000_5000, 32'h0, 5'd7);
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_stb", a_stb, 1);
      tick();
    end
    stalla = 1'b0;
    check_eq("stall_stb4", a_stb, 1);
    tick();
    check_eq("stall_stb_drop", a_stb, 0);
    check_eq("stall_cyc_hold", a_cyc, 1);
    tick();
    check_eq("stall_cyc_wait", a_cyc, 1);
    dat_i = 32'hCAFE_F00D; acka = 1'b1;
    tick();
    acka = 1'b0;
    check_eq("stall_valid", a_valid, 1);
    check_eq("stall_result", a_result, 32'hCAFE_F00D);
    handshake_a();

    // Ack in the same cycle as the unstalled strobe
    issue(0, 0, 3'b100, 32'h0000_1002, 32'h0, 5'd3);
    dat_i = 32'h0055_0000; acka = 1'b1;
    tick();
    acka = 1'b0;
    check_eq("fast_valid", a_valid, 1);
    check_eq("fast_result", a_result, 32'h0000_0055);
    check_eq("fast_cyc", a_cyc, 0);
    handshake_a();

    // Classic mode: stb stays up until ack
    issue(1, 0, 3'b100, 32'h0000_7001, 32'h0, 5'd9);
    check_eq("cl_stb_t1", b_stb, 1);
    tick();
    check_eq("cl_stb_t2", b_stb, 1);
    dat_i = 32'h0000_F000; ackb = 1'b1;
    tick();
    ackb = 1'b0;
    check_eq("cl_valid", b_valid, 1);
    check_eq("cl_result", b_result, 32'h0000_00F0);
    check_eq("cl_stb_t3", b_stb, 0);
    handshake_b();

    // Timeout after four cycles of cyc without ack; late ack ignored
    issue(1, 0, 3'b010, 32'h0000_6000, 32'h0, 5'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("to_cyc_high", b_cyc, 1);
      check_eq("to_stb_high", b_stb, 1);
      if (i < 3) tick();
    end
    tick();
    check_eq("to_cyc_drop", b_cyc, 0);
    check_eq("to_valid", b_valid, 1);
    check_eq("to_berr", b_berr, 1);
    check_eq("to_result", b_result, 0);
    check_eq("to_write", b_write, 0);
    ackb = 1'b1;
    tick();
    check_eq("to_late_valid", b_valid, 1);
    check_eq("to_late_berr", b_berr, 1);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    tick();
    ackb = 1'b0;
    check_eq("to_idle_cyc", b_cyc, 0);
    check_eq("to_idle_valid", b_valid, 0);
    check_eq("to_idle_berr", b_berr, 0);
    check_eq("to_idle_ready", b_iready, 1);

    // Ack on the expiry cycle wins
    issue(1, 0, 3'b010, 32'h0000_8000, 32'h0, 5'd10);
    tick(); tick(); tick();
    dat_i = 32'hDEAD_BEEF; ackb = 1'b1;
    tick();
    ackb = 1'b0;
    check_eq("exp_ack_valid", b_valid, 1);
    check_eq("exp_ack_berr", b_berr, 0);
    check_eq("exp_ack_result", b_result, 32'hDEAD_BEEF);
    check_eq("exp_ack_write", b_write, 1);
    handshake_b();

    // Asynchronous reset while waiting for ack
    issue(0, 0, 3'b010, 32'h0000_9000, 32'h0, 5'd11);
    tick();
    check_eq("mid_cyc_pre", a_cyc, 1);
    check_eq("mid_stb_pre", a_stb, 0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_cyc", a_cyc, 0);
    check_eq("mid_rst_stb", a_stb, 0);
    check_eq("mid_rst_adr", a_adr, 0);
    check_eq("mid_rst_sel", a_sel, 0);
    check_eq("mid_rst_result", a_result, 0);
    check_eq("mid_rst_raddr", a_raddr, 0);
    check_eq("mid_rst_b_result", b_result, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("mid_rel_ready", a_iready, 1);
    check_eq("mid_rel_cyc", a_cyc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
